// File: rtl/qqspi_pkg.sv
// Shared definitions for the qqspi arbiter: FSM encoding, default address windows,
// qqspi word-address width and small address helpers.
package qqspi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

    localparam logic [31:0] FLASH_BASE_DEF = 32'h2000_0000;
    localparam logic [31:0] FLASH_END_DEF  = 32'h2100_0000;
    localparam logic [31:0] PSRAM_BASE_DEF = 32'h8000_0000;
    localparam logic [31:0] PSRAM_END_DEF  = 32'h8080_0000;

    localparam int unsigned MEM_AW = 23;

    function automatic logic [MEM_AW-1:0] word_addr(input logic [31:0] a);
        return {1'b0, a[23:2]};
    endfunction

    // Half-open window test [base, lim), unsigned on 32 bits.
    function automatic logic in_window(input logic [31:0] a,
                                       input logic [31:0] base,
                                       input logic [31:0] lim);
        return (a >= base) && (a < lim);
    endfunction

endpackage

// File: rtl/qqspi_rr_arbiter.sv
// Two-way round-robin grant; on a tie the master that did not win last time is chosen.
module qqspi_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic       gnt_o,
    output logic       any_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        any_o = req_i[0] | req_i[1];
        if (req_i[0] && req_i[1]) begin
            gnt_o = ~last_q;
        end else begin
            gnt_o = req_i[1];
        end
        last_d = (take_i && any_o) ? gnt_o : last_q;
    end

    // Reset to m1 so that m0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/qqspi_arbiter.sv
// Shares one qqspi quad-SPI engine (flash on ce0, PSRAM on ce1) between two masters,
// with region decode, error responses for illegal accesses and a transfer timeout.
module qqspi_arbiter
    import qqspi_pkg::*;
#(
    parameter logic [31:0] FLASH_BASE     = FLASH_BASE_DEF,
    parameter logic [31:0] FLASH_END      = FLASH_END_DEF,
    parameter logic [31:0] PSRAM_BASE     = PSRAM_BASE_DEF,
    parameter logic [31:0] PSRAM_END      = PSRAM_END_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_valid,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic              m0_ready,
    output logic [31:0]       m0_rdata,
    output logic              m0_err,

    input  logic              m1_valid,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic              m1_ready,
    output logic [31:0]       m1_rdata,
    output logic              m1_err,

    output logic              mem_valid,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    output logic              mem_psram,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    localparam int          TW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          TMO_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TMO_MAX = TMO_EN ? TW'(TIMEOUT_CYCLES - 1) : '1;

    state_e              state_q, state_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                gnt_q;
    logic [MEM_AW-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [3:0]          wstrb_q;
    logic                psram_q;

    logic                gnt;
    logic                any_req;
    logic                capture;
    logic [31:0]         sel_addr;
    logic [31:0]         sel_wdata;
    logic [3:0]          sel_wstrb;
    logic                flash_hit;
    logic                psram_hit;
    logic                legal;

    qqspi_rr_arbiter u_rr (
        .clk    (clk),
        .rst    (rst),
        .req_i  ({m1_valid, m0_valid}),
        .take_i (state_q == ST_IDLE),
        .gnt_o  (gnt),
        .any_o  (any_req)
    );

    assign sel_addr  = gnt ? m1_addr  : m0_addr;
    assign sel_wdata = gnt ? m1_wdata : m0_wdata;
    assign sel_wstrb = gnt ? m1_wstrb : m0_wstrb;

    // Flash is read-only; a write into it is treated like a miss.
    assign flash_hit = in_window(sel_addr, FLASH_BASE, FLASH_END);
    assign psram_hit = in_window(sel_addr, PSRAM_BASE, PSRAM_END);
    assign legal     = psram_hit | (flash_hit & (sel_wstrb == 4'b0000));

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        rdata_d = rdata_q;
        capture = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    capture = 1'b1;
                    tmo_d   = '0;
                    state_d = legal ? ST_ISSUE : ST_ERR;
                end
            end
            ST_ISSUE: begin
                if (mem_ready) begin
                    rdata_d = mem_rdata;
                    state_d = ST_RESP;
                end else if (TMO_EN && (tmo_q == TMO_MAX)) begin
                    state_d = ST_ERR;
                end else if (tmo_q != TMO_MAX) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            rdata_q <= rdata_d;
        end
    end

    // Request payload is frozen at grant time so mem_* stay constant through ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            psram_q <= 1'b0;
        end else if (capture) begin
            gnt_q   <= gnt;
            addr_q  <= word_addr(sel_addr);
            wdata_q <= sel_wdata;
            wstrb_q <= sel_wstrb;
            psram_q <= psram_hit;
        end
    end

    assign mem_valid = (state_q == ST_ISSUE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign mem_psram = psram_q;

    always_comb begin
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_rdata = '0;
        m1_rdata = '0;
        m0_err   = 1'b0;
        m1_err   = 1'b0;
        if (state_q == ST_RESP) begin
            if (gnt_q) begin
                m1_ready = 1'b1;
                m1_rdata = rdata_q;
            end else begin
                m0_ready = 1'b1;
                m0_rdata = rdata_q;
            end
        end else if (state_q == ST_ERR) begin
            if (gnt_q) begin
                m1_ready = 1'b1;
                m1_err   = 1'b1;
            end else begin
                m0_ready = 1'b1;
                m0_err   = 1'b1;
            end
        end
    end

endmodule
